// File: rtl/flght_pkg.sv
// flght_pkg: shared widths, speed constants, payload structs and helpers for the
// flight-controller motor mixer (flght_mix).
package flght_pkg;

  localparam int unsigned TERM_P_W = 10;
  localparam int unsigned TERM_D_W = 12;
  localparam int unsigned SUM_W    = 13;
  localparam int unsigned MIX_W    = 14;
  localparam int unsigned SPD_W    = 11;
  localparam int unsigned THR_W    = 9;

  typedef logic        [SPD_W-1:0] spd_t;
  typedef logic signed [MIX_W-1:0] mix_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // Idle offset added to thrust, calibration speed, and slew step limit
  localparam spd_t MIN_RUN_SPEED = spd_t'(512);
  localparam spd_t CAL_SPEED     = spd_t'(432);
  localparam spd_t MAX_STEP      = spd_t'(64);
  localparam spd_t SPD_MAX       = '1;

  // Raw per-axis terms plus thrust, captured on vld
  typedef struct packed {
    logic [THR_W-1:0]    thrst;
    logic [TERM_P_W-1:0] ptch_p;
    logic [TERM_D_W-1:0] ptch_d;
    logic [TERM_P_W-1:0] roll_p;
    logic [TERM_D_W-1:0] roll_d;
    logic [TERM_P_W-1:0] yaw_p;
    logic [TERM_D_W-1:0] yaw_d;
  } term_t;

  // Per-axis P+D sums and offset thrust, ready for mixing
  typedef struct packed {
    spd_t base;
    sum_t ptch;
    sum_t roll;
    sum_t yaw;
  } mix_in_t;

  // Sign-extend P and D terms and add them in SUM_W-bit signed arithmetic
  function automatic sum_t axis_sum(input logic [TERM_P_W-1:0] p,
                                    input logic [TERM_D_W-1:0] d);
    sum_t px;
    sum_t dx;
    px = sum_t'({{(SUM_W-TERM_P_W){p[TERM_P_W-1]}}, p});
    dx = sum_t'({{(SUM_W-TERM_D_W){d[TERM_D_W-1]}}, d});
    return px + dx;
  endfunction

  // Clamp a signed mix result into the unsigned motor speed range
  function automatic spd_t sat_spd(input mix_t m);
    if (m[MIX_W-1]) begin
      return '0;
    end
    if (m > mix_t'({{(MIX_W-SPD_W){1'b0}}, SPD_MAX})) begin
      return SPD_MAX;
    end
    return m[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/flght_mix_sat.sv
// mix_sat: one motor channel. Adds/subtracts two axis sums to the base speed,
// saturates, and registers the result. Optional SLEW_LIMIT_EN bounds the
// per-update output change to MAX_STEP (calibration loads bypass the limit).
module mix_sat
  import flght_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic             cal,
  input  logic             neg_a,
  input  logic             neg_b,
  input  logic [SPD_W-1:0] base,
  input  logic [SUM_W-1:0] sum_a,
  input  logic [SUM_W-1:0] sum_b,
  output logic [SPD_W-1:0] spd
);

  mix_t base_x;
  mix_t a_x;
  mix_t b_x;
  mix_t mix_c;
  spd_t tgt_c;
  spd_t spd_d;
  spd_t spd_q;

  // Widen operands, apply sign selects and saturate to the target speed
  always_comb begin
    base_x = mix_t'({{(MIX_W-SPD_W){1'b0}}, base});
    a_x    = mix_t'({{(MIX_W-SUM_W){sum_a[SUM_W-1]}}, sum_a});
    b_x    = mix_t'({{(MIX_W-SUM_W){sum_b[SUM_W-1]}}, sum_b});
    mix_c  = base_x + (neg_a ? -a_x : a_x) + (neg_b ? -b_x : b_x);
    tgt_c  = sat_spd(mix_c);
  end

  // Next output: hold unless updating; calibration forces CAL_SPEED
  always_comb begin
    spd_d = spd_q;
    if (upd) begin
      if (cal) begin
        spd_d = CAL_SPEED;
      end
`ifdef SLEW_LIMIT_EN
      else if (tgt_c > spd_q) begin
        spd_d = ((tgt_c - spd_q) > MAX_STEP) ? (spd_q + MAX_STEP) : tgt_c;
      end else if (tgt_c < spd_q) begin
        spd_d = ((spd_q - tgt_c) > MAX_STEP) ? (spd_q - MAX_STEP) : tgt_c;
      end
`else
      else begin
        spd_d = tgt_c;
      end
`endif
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q <= '0;
    end else begin
      spd_q <= spd_d;
    end
  end

  assign spd = spd_q;

endmodule

// File: rtl/flght_mix.sv
// flght_mix: three-stage motor mixer. Stage A captures PD terms and thrust on
// vld, stage B forms per-axis sums and the offset base, stage C (mix_sat x4)
// mixes, saturates and registers the four motor speeds.
// Optional build macro: SLEW_LIMIT_EN (per-update slew limit on motor outputs).
module flght_mix
  import flght_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                vld,
  input  logic [THR_W-1:0]    thrst,
  input  logic [TERM_P_W-1:0] ptch_pterm,
  input  logic [TERM_D_W-1:0] ptch_dterm,
  input  logic [TERM_P_W-1:0] roll_pterm,
  input  logic [TERM_D_W-1:0] roll_dterm,
  input  logic [TERM_P_W-1:0] yaw_pterm,
  input  logic [TERM_D_W-1:0] yaw_dterm,
  input  logic                inertial_cal,
  output logic [SPD_W-1:0]    frnt_spd,
  output logic [SPD_W-1:0]    bck_spd,
  output logic [SPD_W-1:0]    lft_spd,
  output logic [SPD_W-1:0]    rght_spd,
  output logic                spd_vld
);

  term_t   a_d, a_q;
  logic    va_d, va_q;
  mix_in_t b_d, b_q;
  logic    vb_d, vb_q;
  logic    spd_vld_d, spd_vld_q;

  // Stage A: capture terms on vld, hold otherwise
  always_comb begin
    a_d  = a_q;
    va_d = vld;
    if (vld) begin
      a_d.thrst  = thrst;
      a_d.ptch_p = ptch_pterm;
      a_d.ptch_d = ptch_dterm;
      a_d.roll_p = roll_pterm;
      a_d.roll_d = roll_dterm;
      a_d.yaw_p  = yaw_pterm;
      a_d.yaw_d  = yaw_dterm;
    end
  end

  // Stage B: per-axis P+D sums and thrust plus idle offset
  always_comb begin
    b_d       = b_q;
    vb_d      = va_q;
    spd_vld_d = vb_q;
    if (va_q) begin
      b_d.base = spd_t'({{(SPD_W-THR_W){1'b0}}, a_q.thrst}) + MIN_RUN_SPEED;
      b_d.ptch = axis_sum(a_q.ptch_p, a_q.ptch_d);
      b_d.roll = axis_sum(a_q.roll_p, a_q.roll_d);
      b_d.yaw  = axis_sum(a_q.yaw_p, a_q.yaw_d);
    end
  end

  // Pipeline and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      va_q      <= 1'b0;
      b_q       <= '0;
      vb_q      <= 1'b0;
      spd_vld_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      va_q      <= va_d;
      b_q       <= b_d;
      vb_q      <= vb_d;
      spd_vld_q <= spd_vld_d;
    end
  end

  assign spd_vld = spd_vld_q;

  // Stage C: front = base + ptch - yaw
  mix_sat u_frnt (
    .clk(clk), .rst(rst), .upd(vb_q), .cal(inertial_cal),
    .neg_a(1'b0), .neg_b(1'b1),
    .base(b_q.base), .sum_a(b_q.ptch), .sum_b(b_q.yaw), .spd(frnt_spd)
  );

  // Stage C: back = base - ptch - yaw
  mix_sat u_bck (
    .clk(clk), .rst(rst), .upd(vb_q), .cal(inertial_cal),
    .neg_a(1'b1), .neg_b(1'b1),
    .base(b_q.base), .sum_a(b_q.ptch), .sum_b(b_q.yaw), .spd(bck_spd)
  );

  // Stage C: left = base + roll + yaw
  mix_sat u_lft (
    .clk(clk), .rst(rst), .upd(vb_q), .cal(inertial_cal),
    .neg_a(1'b0), .neg_b(1'b0),
    .base(b_q.base), .sum_a(b_q.roll), .sum_b(b_q.yaw), .spd(lft_spd)
  );

  // Stage C: right = base - roll + yaw
  mix_sat u_rght (
    .clk(clk), .rst(rst), .upd(vb_q), .cal(inertial_cal),
    .neg_a(1'b1), .neg_b(1'b0),
    .base(b_q.base), .sum_a(b_q.roll), .sum_b(b_q.yaw), .spd(rght_spd)
  );

endmodule

// File: tb/tb_flght_mix.sv
// Testbench for flght_mix: directed test-plan steps followed by random traffic,
// checked against an integer reference model with a latency queue.
`timescale 1ns/1ps
module tb_flght_mix;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [8:0]  thrst;
  logic [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
  logic [11:0] ptch_dterm, roll_dterm, yaw_dterm;
  logic        inertial_cal;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        spd_vld;

  flght_mix dut (
    .clk(clk), .rst(rst), .vld(vld), .thrst(thrst),
    .ptch_pterm(ptch_pterm), .ptch_dterm(ptch_dterm),
    .roll_pterm(roll_pterm), .roll_dterm(roll_dterm),
    .yaw_pterm(yaw_pterm), .yaw_dterm(yaw_dterm),
    .inertial_cal(inertial_cal),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t[4];
    int due;
  } exp_t;

  exp_t q[$];
  int   m_spd[4];
  int   cyc;
  int   n_assert;
  int   n_fail;
  int   s_th, s_pp, s_pd, s_rp, s_rd, s_yp, s_yd;

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one motor update to the model: calibration wins, else target (slew-limited if enabled)
  task automatic model_update(input exp_t e);
    for (int i = 0; i < 4; i++) begin
      if (inertial_cal) begin
        m_spd[i] = 432;
      end else begin
`ifdef SLEW_LIMIT_EN
        if (e.t[i] > m_spd[i])
          m_spd[i] = m_spd[i] + ((e.t[i] - m_spd[i]) > 64 ? 64 : (e.t[i] - m_spd[i]));
        else if (e.t[i] < m_spd[i])
          m_spd[i] = m_spd[i] - ((m_spd[i] - e.t[i]) > 64 ? 64 : (m_spd[i] - e.t[i]));
`else
        m_spd[i] = e.t[i];
`endif
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 4; i++) m_spd[i] = 0;
  endtask

  // One clock: model the edge, then compare everything at the falling edge
  task automatic tick();
    exp_t e;
    bit   ev;
    int   base, p, r, y;
    @(posedge clk);
    cyc++;
    ev = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        ev = 1'b1;
        model_update(e);
      end
      if (vld) begin
        base = s_th + 512;
        p = s_pp + s_pd;
        r = s_rp + s_rd;
        y = s_yp + s_yd;
        e.t[0] = clamp(base + p - y);
        e.t[1] = clamp(base - p - y);
        e.t[2] = clamp(base + r + y);
        e.t[3] = clamp(base - r + y);
        e.due = cyc + 2;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check("spd_vld", 32'(spd_vld), 32'(ev));
    check("frnt_spd", 32'(frnt_spd), m_spd[0]);
    check("bck_spd", 32'(bck_spd), m_spd[1]);
    check("lft_spd", 32'(lft_spd), m_spd[2]);
    check("rght_spd", 32'(rght_spd), m_spd[3]);
  endtask

  task automatic send(input int th, input int pp, input int pd, input int rp,
                      input int rd, input int yp, input int yd);
    s_th = th; s_pp = pp; s_pd = pd; s_rp = rp; s_rd = rd; s_yp = yp; s_yd = yd;
    thrst      = 9'(th);
    ptch_pterm = 10'(pp);
    ptch_dterm = 12'(pd);
    roll_pterm = 10'(rp);
    roll_dterm = 12'(rd);
    yaw_pterm  = 10'(yp);
    yaw_dterm  = 12'(yd);
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_all(input string tag, input int f, input int b, input int l, input int r);
    check({tag, "_frnt"}, 32'(frnt_spd), f);
    check({tag, "_bck"}, 32'(bck_spd), b);
    check({tag, "_lft"}, 32'(lft_spd), l);
    check({tag, "_rght"}, 32'(rght_spd), r);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    vld = 1'b0;
    inertial_cal = 1'b0;
    thrst = '0;
    ptch_pterm = '0; ptch_dterm = '0;
    roll_pterm = '0; roll_dterm = '0;
    yaw_pterm = '0; yaw_dterm = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_spd_vld", 32'(spd_vld), 0);
    check_all("rst", 0, 0, 0, 0);
    rst = 1'b0;
    idle(2);

    // Basic mix
    send(100, 10, 20, 0, 0, 5, -3);
    tick(); tick();
    check("basic_vld", 32'(spd_vld), 1);
`ifndef SLEW_LIMIT_EN
    check_all("basic", 640, 580, 614, 614);
`endif
    idle(2);

    // Saturation at both ends
    send(511, 511, 2047, 0, 0, 0, 0);
    tick(); tick();
`ifndef SLEW_LIMIT_EN
    check_all("sat", 2047, 0, 1023, 1023);
`endif
    idle(2);

    // Back-to-back throughput
    for (int i = 0; i < 5; i++) send(i, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("tput_vld_first", 32'(spd_vld), 1);
    idle(4);
`ifndef SLEW_LIMIT_EN
    check_all("tput_last", 516, 516, 516, 516);
`endif
    idle(2);

    // Calibration forces CAL_SPEED, then normal mixing resumes
    inertial_cal = 1'b1;
    send(100, 10, 20, 0, 0, 5, -3);
    tick(); tick();
    check_all("cal", 432, 432, 432, 432);
    inertial_cal = 1'b0;
    send(100, 10, 20, 0, 0, 5, -3);
    tick(); tick();
`ifndef SLEW_LIMIT_EN
    check_all("cal_off", 640, 580, 614, 614);
`endif
    idle(2);

    // Reset mid-flight: update in flight is discarded
    send(100, 10, 20, 0, 0, 5, -3);
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_vld", 32'(spd_vld), 0);
    check_all("midrst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    idle(5);

`ifdef SLEW_LIMIT_EN
    // Slew-limited approach from zero
    for (int k = 1; k <= 11; k++) begin
      send(100, 10, 20, 0, 0, 5, -3);
      tick(); tick();
      check("slew_frnt", 32'(frnt_spd), (64 * k > 640) ? 640 : 64 * k);
      check("slew_bck", 32'(bck_spd), (64 * k > 580) ? 580 : 64 * k);
    end
    idle(2);
`endif

    // Random traffic with random calibration toggles
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) inertial_cal = ~inertial_cal;
      if ($urandom_range(0, 9) < 6) begin
        send(int'($urandom_range(0, 511)),
             int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 4095)) - 2048);
      end else begin
        idle(1);
      end
    end
    inertial_cal = 1'b0;
    idle(4);
    check("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
